sincos_table_loader: RTL and testbench

Writer-side master for the dual-port sine/cosine SRAM that the counter phase accumulator reads on port 1. Accepts a stream of (sin, cos) sample pairs over a valid/ready handshake and sequences them into SRAM port 0 at addresses 0..DEPTH-1. When the table is complete it releases the read port (csb1) to the counter. This replaces bench-driven table initialisation with in-design loading from a host or ROM streamer.

---
 rtl/sincos_table_loader_pkg.sv | 19 +
 rtl/sincos_table_loader.sv | 113 +++++++++++
 tb/tb_sincos_table_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sincos_table_loader_pkg.sv
// Shared constants and state type for the sine/cosine table loader.
package sincos_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

  // SRAM control pins are active-low
  localparam logic SEL_ON  = 1'b0;
  localparam logic SEL_OFF = 1'b1;
  localparam logic WE_ON   = 1'b0;
  localparam logic WE_OFF  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sincos_table_loader.sv
// Streams (sin, cos) sample pairs into SRAM port 0 at addresses 0..DEPTH-1,
// then releases SRAM port 1 to the phase-accumulator reader.
module sincos_table_loader
  import sincos_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned WMASK_W = DATA_W / 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_sin,
  input  logic [DATA_W-1:0]  s_cos,
  output logic               csb0,
  output logic               web0,
  output logic [WMASK_W-1:0] wmask0,
  output logic [ADDR_W-1:0]  addr0,
  output logic [DATA_W-1:0]  din00,
  output logic [DATA_W-1:0]  din01,
  output logic               csb1,
  output logic               busy,
  output logic               done
);

  state_t             state_q;
  logic [ADDR_W-1:0]  count_q;

  // Ready is a direct decode of the state; abort still wins inside LOAD.
  always_comb begin
    s_ready = (state_q == LOAD);
  end

  // FSM, address counter and registered SRAM port controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      csb0    <= SEL_OFF;
      web0    <= WE_OFF;
      wmask0  <= '0;
      addr0   <= '0;
      din00   <= '0;
      din01   <= '0;
      csb1    <= SEL_OFF;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // No write unless a beat is accepted below
      csb0 <= SEL_OFF;
      web0 <= WE_OFF;
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          csb1 <= SEL_OFF;
          if (start) begin
            state_q <= LOAD;
            count_q <= '0;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            state_q <= IDLE;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            csb1    <= SEL_OFF;
          end else if (s_valid) begin
            csb0    <= SEL_ON;
            web0    <= WE_ON;
            wmask0  <= '1;
            addr0   <= count_q;
            din00   <= s_sin;
            din01   <= s_cos;
            count_q <= count_q + 1'b1;
            // Final address written: count wraps to 0, so DEPTH is never targeted
            if (count_q == {ADDR_W{1'b1}}) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (start) begin
            // Pull the read port away before any rewrite reaches the SRAM
            state_q <= LOAD;
            count_q <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            csb1    <= SEL_OFF;
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
            csb1 <= SEL_ON;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          csb1    <= SEL_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_table_loader.sv
// Randomized self-checking bench for sincos_table_loader with a
// transaction-level model of the load sequence and a behavioural SRAM.
module tb_sincos_table_loader;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int WMASK_W = DATA_W / 8;
  localparam int DEPTH   = 1 << ADDR_W;

  logic               clk = 1'b0;
  logic               reset, start, abort, s_valid, s_ready;
  logic [DATA_W-1:0]  s_sin, s_cos;
  logic               csb0, web0, csb1, busy, done;
  logic [WMASK_W-1:0] wmask0;
  logic [ADDR_W-1:0]  addr0;
  logic [DATA_W-1:0]  din00, din01;

  sincos_table_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WMASK_W(WMASK_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_sin(s_sin), .s_cos(s_cos),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din00(din00), .din01(din01), .csb1(csb1), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: phase 0=idle, 1=loading, 2=table complete; m_cnt = beats taken so far
  int m_phase = 0;
  int m_cnt   = 0;
  int writes  = 0;
  logic [DATA_W-1:0] exp_sin [DEPTH];
  logic [DATA_W-1:0] exp_cos [DEPTH];
  logic [DATA_W-1:0] mem_sin [DEPTH];
  logic [DATA_W-1:0] mem_cos [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, model the edge, check at the next negedge.
  task automatic step(input logic v, input logic [DATA_W-1:0] sn, input logic [DATA_W-1:0] cs,
                      input logic st, input logic ab);
    logic acc;
    logic e_busy, e_done, e_csb1;
    int   e_addr;
    s_valid = v; s_sin = sn; s_cos = cs; start = st; abort = ab;
    @(posedge clk);
    acc = 1'b0; e_addr = 0;
    e_busy = 1'b0; e_done = 1'b0; e_csb1 = 1'b1;
    if (m_phase == 0) begin
      if (st) begin m_phase = 1; m_cnt = 0; e_busy = 1'b1; end
    end else if (m_phase == 1) begin
      if (ab) begin
        m_phase = 0; m_cnt = 0;
      end else begin
        e_busy = 1'b1;
        if (v) begin
          acc = 1'b1; e_addr = m_cnt;
          exp_sin[m_cnt] = sn; exp_cos[m_cnt] = cs;
          m_cnt++;
          if (m_cnt == DEPTH) begin m_phase = 2; m_cnt = 0; end
        end
      end
    end else begin
      if (st) begin m_phase = 1; m_cnt = 0; e_busy = 1'b1; end
      else begin e_done = 1'b1; e_csb1 = 1'b0; end
    end
    @(negedge clk);
    check("csb0", csb0, !acc);
    check("web0", web0, !acc);
    if (acc) begin
      check("addr0", addr0, e_addr);
      check("din00", din00, exp_sin[e_addr]);
      check("din01", din01, exp_cos[e_addr]);
      check("wmask0", wmask0, {WMASK_W{1'b1}});
    end
    check("s_ready", s_ready, m_phase == 1);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("csb1", csb1, e_csb1);
    if (!csb0 && !web0 && wmask0 == {WMASK_W{1'b1}}) begin
      mem_sin[addr0] = din00;
      mem_cos[addr0] = din01;
      writes++;
    end
    s_valid = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  // Offer n beats while loading; gap_pct = chance of a bubble, rnd selects data kind.
  task automatic load_beats(input int n, input int gap_pct, input bit rnd);
    int taken = 0;
    int iter  = 0;
    logic v;
    logic [DATA_W-1:0] sn, cs;
    while (taken < n && iter < 20000) begin
      v = ($urandom_range(99) >= gap_pct);
      if (rnd) begin sn = $urandom; cs = $urandom; end
      else begin
        sn = DATA_W'(m_cnt) * 32'h0100_0000;
        cs = ~DATA_W'(m_cnt);
      end
      step(v, sn, cs, 1'b0, 1'b0);
      if (v) taken++;
      iter++;
    end
    check("load_budget", taken, n);
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_sin[i] !== exp_sin[i] || mem_cos[i] !== exp_cos[i]) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_csb0"}, csb0, 1'b1);
    check({tag, "_web0"}, web0, 1'b1);
    check({tag, "_csb1"}, csb1, 1'b1);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_wmask0"}, wmask0, '0);
    check({tag, "_addr0"}, addr0, '0);
    check({tag, "_din"}, {din00, din01}, '0);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_sin[i] = '0; exp_cos[i] = '0; mem_sin[i] = '0; mem_cos[i] = '0;
    end
    reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_sin = '0; s_cos = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    // Idle ignores beats and abort
    step(1'b1, 32'h1234, 32'h5678, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);

    // Full load with ramp data, no gaps
    step(1'b0, '0, '0, 1'b1, 1'b0);
    w0 = writes;
    load_beats(DEPTH, 0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("full_writes", writes - w0, DEPTH);
    check("full_phase_done", m_phase, 2);
    check_mem("full_mem");

    // start+abort in DONE: reload wins, then a gappy random load
    step(1'b0, '0, '0, 1'b1, 1'b1);
    w0 = writes;
    load_beats(DEPTH, 50, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("bubble_writes", writes - w0, DEPTH);
    check_mem("bubble_mem");

    // Abort with a beat offered at beat 100: the beat must be dropped
    step(1'b0, '0, '0, 1'b1, 1'b0);
    load_beats(100, 20, 1'b1);
    w0 = writes;
    step(1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b1);
    check("abort_no_write", writes - w0, 0);
    check_mem("abort_mem");

    // start+abort in IDLE: start wins; then start+abort in LOAD: abort wins
    step(1'b0, '0, '0, 1'b1, 1'b1);
    load_beats(5, 0, 1'b1);
    step(1'b1, 32'h1, 32'h2, 1'b1, 1'b1);
    check("sa_load_idle", m_phase, 0);
    check_mem("sa_mem");

    // Async reset mid-load
    step(1'b0, '0, '0, 1'b1, 1'b0);
    load_beats(40, 10, 1'b1);
    s_valid = 1'b1;
    step(1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_values("async_rst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_phase = 0; m_cnt = 0;
    check_mem("async_mem");

    // Reload after reset from address 0
    step(1'b0, '0, '0, 1'b1, 1'b0);
    w0 = writes;
    load_beats(DEPTH, 25, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("final_writes", writes - w0, DEPTH);
    check_mem("final_mem");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
